snake_pixel_generator: RTL and testbench
========================================

Name: snake_pixel_generator

Overview:
- Upstream colour source for the VGA output stage of the Snake game.
- Holds snake state: head, body segments, direction, length and a move timer.
- Advances the snake on a periodic move tick.
- For every pixel address supplied by the VGA stage (ADDRH/ADDRV), returns a registered 12-bit colour for snake head, body, target or background.

Parameters:
- MAX_LENGTH, 16: number of segment registers, including the head.
- INIT_LENGTH, 4: snake length after reset.
- MOVE_PERIOD, 10000000: CLK cycles between moves while GAME_RUN=1.
- GRID_X_MAX, 159: last grid column. Grid cell = 4x4 pixels.
- GRID_Y_MAX, 119: last grid row.

Ports:
- CLK, input, 1: system clock (100 MHz).
- RESET, input, 1: asynchronous, active-high reset.
- GAME_RUN, input, 1: enables the move timer and movement.
- DIR_IN, input, 2: requested direction. 0=up, 1=right, 2=down, 3=left.
- DIR_VALID, input, 1: one-cycle strobe qualifying DIR_IN.
- TARGET_X, input, 8: target grid column.
- TARGET_Y, input, 7: target grid row.
- ADDRH, input, 10: pixel column 0..639 from the VGA stage.
- ADDRV, input, 9: pixel row 0..479 from the VGA stage.
- COLOUR_OUT, output, 12: pixel colour to the VGA stage COLOUR_IN. Packing: [11:8]=blue, [7:4]=red, [3:0]=green.
- TARGET_REACHED, output, 1: one-cycle pulse when the head lands on the target.
- SELF_HIT, output, 1: sticky flag, set on head/body collision.

Behaviour:
- Reset values:
  - seg[0] (head) = (80,60); seg[i] = (80-i,60) for i=1..MAX_LENGTH-1.
  - dir = right; length = INIT_LENGTH; move counter = 0.
  - COLOUR_OUT = 12'h000; TARGET_REACHED = 0; SELF_HIT = 0.
- Direction register:
  - On DIR_VALID, dir <= DIR_IN, unless DIR_IN is the exact opposite of the current dir. Opposites are ignored.
  - Non-strobed DIR_IN values are ignored.
- Move timer:
  - Counts 0..MOVE_PERIOD-1 while GAME_RUN=1 and SELF_HIT=0.
  - At terminal count: raises an internal move strobe for one cycle, then wraps to 0.
  - GAME_RUN=0 holds the count; no moves occur.
- Move (on the move strobe):
  - seg[i] <= seg[i-1] for i=1..MAX_LENGTH-1.
  - Head steps one cell in the dir value registered in that cycle. A DIR_VALID in the same cycle takes effect from the next move.
- Wrap-around: x 159+1 -> 0; x 0-1 -> 159; y 119+1 -> 0; y 0-1 -> 119. Grid arithmetic is done modulo in-range, never bit truncation.
- Collision and target check:
  - Evaluated the cycle after each move on the new head.
  - If head equals seg[i] for any 1 <= i < length: SELF_HIT <= 1. SELF_HIT holds until RESET and freezes movement.
  - Else if head == (TARGET_X,TARGET_Y): TARGET_REACHED pulses high for exactly one cycle, and length <= length+1, saturating at MAX_LENGTH.
  - A collision suppresses the target pulse and growth.
- Segments:
  - Segments with index >= length are stored (shifted) but are neither drawn nor collision-checked.
  - Growth exposes the already-shifted trailing segment.
- Rendering:
  - cell = (ADDRH>>2, ADDRV>>2).
  - Priority order:
    - head -> 12'h0F0 (red);
    - active body -> 12'h00F (green);
    - target -> 12'h0FF (yellow);
    - otherwise -> 12'hF00 (blue).
  - COLOUR_OUT is registered on CLK with latency 1 CLK from ADDRH/ADDRV.
  - Rendering runs every cycle, independent of GAME_RUN and SELF_HIT; it shows the frozen state after a hit.
- Reset mid-move: asynchronous RESET forces all reset values immediately. A pending move strobe is discarded.

Test Plan:
- Reset render: release RESET, set (ADDRH,ADDRV)=(320,240) -> COLOUR_OUT=12'h0F0 after 1 clk. At (316,240): 12'h00F. At (300,240): 12'hF00.
- Move/timer (MOVE_PERIOD=4): GAME_RUN=1 for 4 clks -> head (81,60), tail segment (78,60). GAME_RUN=0 for 20 clks -> no further move.
- Reversal: dir=right, strobe DIR_IN=3 -> dir stays right. Strobe DIR_IN=0 -> next move head y 60->59.
- Wrap: steer head to x=159 heading right, one move -> head (0,y). Heading up from y=0 -> y=119.
- Target growth: TARGET=(81,60), one move -> TARGET_REACHED high exactly 1 clk. Length 4->5: cell (77,60) now renders 12'h00F.
- Self-hit: with length 5, issue up, left, down in consecutive moves -> SELF_HIT=1. The move counter freezes, no TARGET_REACHED fires, and only RESET clears it.

Source files
------------

// File: rtl/snake_pixel_generator_if.sv
// snake_pixel_generator_if: game-control and pixel-lookup signals between the Snake game logic and the VGA stage.
interface snake_pixel_generator_if;
  logic        game_run_i;
  logic [1:0]  dir_i;
  logic        dir_valid_i;
  logic [7:0]  target_x_i;
  logic [6:0]  target_y_i;
  logic [9:0]  addrh_i;
  logic [8:0]  addrv_i;
  logic [11:0] colour_o;
  logic        target_reached_o;
  logic        self_hit_o;
  modport master (
    output game_run_i, dir_i, dir_valid_i, target_x_i, target_y_i, addrh_i, addrv_i,
    input  colour_o, target_reached_o, self_hit_o
  );
  modport slave (
    input  game_run_i, dir_i, dir_valid_i, target_x_i, target_y_i, addrh_i, addrv_i,
    output colour_o, target_reached_o, self_hit_o
  );
endinterface

// File: rtl/snake_pixel_generator.sv
// snake_pixel_generator: holds and moves the snake on a toroidal grid and returns a registered colour per pixel.
module snake_pixel_generator #(
  parameter int MAX_LENGTH  = 16,
  parameter int INIT_LENGTH = 4,
  parameter int MOVE_PERIOD = 10000000,
  parameter int GRID_X_MAX  = 159,
  parameter int GRID_Y_MAX  = 119
) (
  input logic clk,
  input logic rst,
  snake_pixel_generator_if.slave bus
);
  localparam int CW = $clog2(MOVE_PERIOD + 1);
  localparam int LW = $clog2(MAX_LENGTH + 1);
  typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_e;
  logic [7:0]    x_q [MAX_LENGTH];
  logic [6:0]    y_q [MAX_LENGTH];
  dir_e          dir_q;
  logic [LW-1:0] len_q;
  logic [CW-1:0] cnt_q;
  logic          chk_q, hit_q, tr_q;
  logic [11:0]   col_q;
  logic [7:0]    hx_d, cx;
  logic [6:0]    hy_d, cy;
  logic          move, hit, on_tgt, head_px, body_px, tgt_px;
  always_comb begin
    move    = bus.game_run_i && !hit_q && cnt_q == CW'(MOVE_PERIOD - 1);
    hx_d    = dir_q == RIGHT ? (x_q[0] == 8'(GRID_X_MAX) ? 8'd0 : x_q[0] + 8'd1) :
              dir_q == LEFT  ? (x_q[0] == 8'd0 ? 8'(GRID_X_MAX) : x_q[0] - 8'd1) : x_q[0];
    hy_d    = dir_q == DOWN  ? (y_q[0] == 7'(GRID_Y_MAX) ? 7'd0 : y_q[0] + 7'd1) :
              dir_q == UP    ? (y_q[0] == 7'd0 ? 7'(GRID_Y_MAX) : y_q[0] - 7'd1) : y_q[0];
    cx      = 8'(bus.addrh_i >> 2);
    cy      = 7'(bus.addrv_i >> 2);
    head_px = x_q[0] == cx && y_q[0] == cy;
    tgt_px  = cx == bus.target_x_i && cy == bus.target_y_i;
    on_tgt  = x_q[0] == bus.target_x_i && y_q[0] == bus.target_y_i;
    hit     = 1'b0;
    body_px = 1'b0;
    // Trailing segments beyond the live length are kept shifted but stay invisible.
    for (int i = 1; i < MAX_LENGTH; i++) begin
      if (i < int'(len_q)) begin
        hit     = hit | (x_q[i] == x_q[0] && y_q[i] == y_q[0]);
        body_px = body_px | (x_q[i] == cx && y_q[i] == cy);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LENGTH; i++) begin
        x_q[i] <= 8'(80 - i);
        y_q[i] <= 7'd60;
      end
      dir_q <= RIGHT;
      len_q <= LW'(INIT_LENGTH);
      cnt_q <= '0;
      chk_q <= 1'b0;
      hit_q <= 1'b0;
      tr_q  <= 1'b0;
      col_q <= 12'h000;
    end else begin
      if (bus.dir_valid_i && bus.dir_i != (dir_q ^ 2'd2)) dir_q <= dir_e'(bus.dir_i);
      if (bus.game_run_i && !hit_q) cnt_q <= move ? '0 : cnt_q + CW'(1);
      if (move) begin
        for (int i = 1; i < MAX_LENGTH; i++) begin
          x_q[i] <= x_q[i-1];
          y_q[i] <= y_q[i-1];
        end
        x_q[0] <= hx_d;
        y_q[0] <= hy_d;
      end
      // The new head is judged one cycle after the move; a collision masks the target.
      chk_q <= move;
      tr_q  <= chk_q && !hit && on_tgt;
      if (chk_q && hit) hit_q <= 1'b1;
      if (chk_q && !hit && on_tgt && len_q != LW'(MAX_LENGTH)) len_q <= len_q + LW'(1);
      col_q <= head_px ? 12'h0F0 : body_px ? 12'h00F : tgt_px ? 12'h0FF : 12'hF00;
    end
  end
  assign bus.colour_o         = col_q;
  assign bus.target_reached_o = tr_q;
  assign bus.self_hit_o       = hit_q;
endmodule

// File: tb/tb_snake_pixel_generator.sv
// tb_snake_pixel_generator: directed scenarios plus randomized play checked against a grid-level snake model.
module tb_snake_pixel_generator;
  localparam int P  = 4;
  localparam int ML = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  snake_pixel_generator_if bus();
  snake_pixel_generator #(.MAX_LENGTH(ML), .INIT_LENGTH(4), .MOVE_PERIOD(P), .GRID_X_MAX(159), .GRID_Y_MAX(119))
    dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int mx[ML];
  int my[ML];
  int mdir, mlen, mcnt;
  bit mhit, mpend, exp_tr;
  logic [11:0] exp_col;
  int dx[4] = '{0, 1, 0, -1};
  int dy[4] = '{-1, 0, 1, 0};
  function automatic logic [11:0] m_render(int cx, int cy);
    if (mx[0] == cx && my[0] == cy) return 12'h0F0;
    for (int i = 1; i < mlen; i++) if (mx[i] == cx && my[i] == cy) return 12'h00F;
    if (cx == int'(bus.target_x_i) && cy == int'(bus.target_y_i)) return 12'h0FF;
    return 12'hF00;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < ML; i++) begin mx[i] = 80 - i; my[i] = 60; end
    mdir = 1; mlen = 4; mcnt = 0; mhit = 0; mpend = 0; exp_tr = 0;
  endtask
  // Advance model by one clock using the inputs currently applied, then clock the DUT.
  task automatic cyc();
    bit nhit, coll;
    exp_col = m_render(int'(bus.addrh_i) / 4, int'(bus.addrv_i) / 4);
    exp_tr = 0;
    nhit = mhit;
    if (mpend) begin
      coll = 0;
      for (int i = 1; i < mlen; i++) if (mx[i] == mx[0] && my[i] == my[0]) coll = 1;
      if (coll) nhit = 1;
      else if (mx[0] == int'(bus.target_x_i) && my[0] == int'(bus.target_y_i)) begin
        exp_tr = 1;
        if (mlen < ML) mlen++;
      end
    end
    mpend = 0;
    if (bus.game_run_i && !mhit) begin
      mcnt++;
      if (mcnt == P) begin
        mcnt = 0;
        for (int i = ML - 1; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
        mx[0] = (mx[0] + dx[mdir] + 160) % 160;
        my[0] = (my[0] + dy[mdir] + 120) % 120;
        mpend = 1;
      end
    end
    if (bus.dir_valid_i && int'(bus.dir_i) != (mdir + 2) % 4) mdir = int'(bus.dir_i);
    mhit = nhit;
    @(posedge clk);
    #1;
  endtask
  task automatic probe(int x, int y);
    bus.addrh_i = 10'(x * 4 + $urandom_range(3));
    bus.addrv_i = 9'(y * 4 + $urandom_range(3));
    cyc();
  endtask
  task automatic run_moves(int n);
    bus.game_run_i = 1;
    repeat (n * P) cyc();
    bus.game_run_i = 0;
  endtask
  task automatic strobe(int d);
    bus.dir_valid_i = 1;
    bus.dir_i = 2'(d);
    cyc();
    bus.dir_valid_i = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.colour_o !== 12'h000) begin n_bad++; $display("FAIL reset_colour: got %h want 000", bus.colour_o); end
    n_cmp++; if (bus.target_reached_o !== 1'b0) begin n_bad++; $display("FAIL reset_tr: got %b want 0", bus.target_reached_o); end
    n_cmp++; if (bus.self_hit_o !== 1'b0) begin n_bad++; $display("FAIL reset_hit: got %b want 0", bus.self_hit_o); end
    rst = 0;
    bus.addrh_i = 10'd320; bus.addrv_i = 9'd240; cyc();
    n_cmp++; if (bus.colour_o !== 12'h0F0) begin n_bad++; $display("FAIL reset_head: got %h want 0F0", bus.colour_o); end
    bus.addrh_i = 10'd316; cyc();
    n_cmp++; if (bus.colour_o !== 12'h00F) begin n_bad++; $display("FAIL reset_body: got %h want 00F", bus.colour_o); end
    bus.addrh_i = 10'd300; cyc();
    n_cmp++; if (bus.colour_o !== 12'hF00) begin n_bad++; $display("FAIL reset_bg: got %h want F00", bus.colour_o); end
  endtask
  task automatic test_move();
    run_moves(1);
    probe(81, 60);
    n_cmp++; if (bus.colour_o !== 12'h0F0) begin n_bad++; $display("FAIL move_head: got %h want 0F0", bus.colour_o); end
    probe(78, 60);
    n_cmp++; if (bus.colour_o !== 12'h00F) begin n_bad++; $display("FAIL move_tail: got %h want 00F", bus.colour_o); end
    probe(77, 60);
    n_cmp++; if (bus.colour_o !== 12'hF00) begin n_bad++; $display("FAIL move_old_tail: got %h want F00", bus.colour_o); end
    repeat (20) cyc();
    probe(81, 60);
    n_cmp++; if (bus.colour_o !== 12'h0F0) begin n_bad++; $display("FAIL hold_head: got %h want 0F0", bus.colour_o); end
    probe(82, 60);
    n_cmp++; if (bus.colour_o !== 12'hF00) begin n_bad++; $display("FAIL hold_no_move: got %h want F00", bus.colour_o); end
  endtask
  task automatic test_reversal();
    strobe(3);
    run_moves(1);
    probe(82, 60);
    n_cmp++; if (bus.colour_o !== 12'h0F0) begin n_bad++; $display("FAIL reverse_ignored: got %h want 0F0", bus.colour_o); end
    strobe(0);
    run_moves(1);
    probe(82, 59);
    n_cmp++; if (bus.colour_o !== 12'h0F0) begin n_bad++; $display("FAIL turn_up: got %h want 0F0", bus.colour_o); end
  endtask
  task automatic test_wrap();
    strobe(1);
    run_moves(77);
    probe(159, 59);
    n_cmp++; if (bus.colour_o !== 12'h0F0) begin n_bad++; $display("FAIL wrap_edge_x: got %h want 0F0", bus.colour_o); end
    run_moves(1);
    probe(0, 59);
    n_cmp++; if (bus.colour_o !== 12'h0F0) begin n_bad++; $display("FAIL wrap_x: got %h want 0F0", bus.colour_o); end
    probe(159, 59);
    n_cmp++; if (bus.colour_o !== 12'h00F) begin n_bad++; $display("FAIL wrap_x_body: got %h want 00F", bus.colour_o); end
    strobe(0);
    run_moves(60);
    probe(0, 119);
    n_cmp++; if (bus.colour_o !== 12'h0F0) begin n_bad++; $display("FAIL wrap_y: got %h want 0F0", bus.colour_o); end
    probe(0, 0);
    n_cmp++; if (bus.colour_o !== 12'h00F) begin n_bad++; $display("FAIL wrap_y_body: got %h want 00F", bus.colour_o); end
  endtask
  task automatic test_target();
    do_reset();
    bus.target_x_i = 8'd81; bus.target_y_i = 7'd60;
    probe(81, 60);
    n_cmp++; if (bus.colour_o !== 12'h0FF) begin n_bad++; $display("FAIL target_colour: got %h want 0FF", bus.colour_o); end
    bus.game_run_i = 1;
    repeat (P) cyc();
    bus.game_run_i = 0;
    n_cmp++; if (bus.target_reached_o !== 1'b0) begin n_bad++; $display("FAIL target_early: got %b want 0", bus.target_reached_o); end
    cyc();
    n_cmp++; if (bus.target_reached_o !== 1'b1) begin n_bad++; $display("FAIL target_pulse: got %b want 1", bus.target_reached_o); end
    cyc();
    n_cmp++; if (bus.target_reached_o !== 1'b0) begin n_bad++; $display("FAIL target_one_cycle: got %b want 0", bus.target_reached_o); end
    probe(77, 60);
    n_cmp++; if (bus.colour_o !== 12'h00F) begin n_bad++; $display("FAIL growth_tail: got %h want 00F", bus.colour_o); end
  endtask
  task automatic test_self_hit();
    bit tr_seen;
    bus.target_x_i = 8'd80; bus.target_y_i = 7'd60;
    strobe(0); run_moves(1);
    strobe(3); run_moves(1);
    strobe(2);
    bus.game_run_i = 1;
    tr_seen = 0;
    repeat (P) begin cyc(); tr_seen |= bus.target_reached_o; end
    n_cmp++; if (bus.self_hit_o !== 1'b0) begin n_bad++; $display("FAIL hit_early: got %b want 0", bus.self_hit_o); end
    repeat (20) begin cyc(); tr_seen |= bus.target_reached_o; end
    bus.game_run_i = 0;
    n_cmp++; if (bus.self_hit_o !== 1'b1) begin n_bad++; $display("FAIL hit_set: got %b want 1", bus.self_hit_o); end
    n_cmp++; if (tr_seen !== 1'b0) begin n_bad++; $display("FAIL hit_no_target: got %b want 0", tr_seen); end
    probe(80, 60);
    n_cmp++; if (bus.colour_o !== 12'h0F0) begin n_bad++; $display("FAIL hit_frozen_head: got %h want 0F0", bus.colour_o); end
    probe(80, 61);
    n_cmp++; if (bus.colour_o !== 12'hF00) begin n_bad++; $display("FAIL hit_no_move: got %h want F00", bus.colour_o); end
    probe(81, 59);
    n_cmp++; if (bus.colour_o !== 12'h00F) begin n_bad++; $display("FAIL hit_body: got %h want 00F", bus.colour_o); end
    rst = 1;
    #1;
    n_cmp++; if (bus.self_hit_o !== 1'b0) begin n_bad++; $display("FAIL async_reset_hit: got %b want 0", bus.self_hit_o); end
    n_cmp++; if (bus.colour_o !== 12'h000) begin n_bad++; $display("FAIL async_reset_colour: got %h want 000", bus.colour_o); end
    m_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic test_random();
    int cx, cy;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.game_run_i = ($urandom_range(9) != 0);
      bus.dir_valid_i = ($urandom_range(5) == 0);
      bus.dir_i = 2'($urandom_range(3));
      if ($urandom_range(40) == 0) begin
        bus.target_x_i = 8'((mx[0] + dx[mdir] * int'($urandom_range(1, 4)) + 160) % 160);
        bus.target_y_i = 7'((my[0] + dy[mdir] * int'($urandom_range(1, 4)) + 120) % 120);
      end
      if ($urandom_range(1) == 0) begin
        cx = (mx[0] + int'($urandom_range(4)) - 2 + 160) % 160;
        cy = (my[0] + int'($urandom_range(4)) - 2 + 120) % 120;
        bus.addrh_i = 10'(cx * 4 + $urandom_range(3));
        bus.addrv_i = 9'(cy * 4 + $urandom_range(3));
      end else begin
        bus.addrh_i = 10'($urandom_range(639));
        bus.addrv_i = 9'($urandom_range(479));
      end
      cyc();
      n_cmp++; if (bus.colour_o !== exp_col) begin n_bad++; $display("FAIL rand_colour @%0d: got %h want %h", n, bus.colour_o, exp_col); end
      n_cmp++; if (bus.target_reached_o !== exp_tr) begin n_bad++; $display("FAIL rand_tr @%0d: got %b want %b", n, bus.target_reached_o, exp_tr); end
      n_cmp++; if (bus.self_hit_o !== mhit) begin n_bad++; $display("FAIL rand_hit @%0d: got %b want %b", n, bus.self_hit_o, mhit); end
      if (mhit && $urandom_range(15) == 0) begin
        bus.dir_valid_i = 0;
        do_reset();
      end
    end
    bus.dir_valid_i = 0;
    bus.game_run_i = 0;
  endtask
  initial begin
    bus.game_run_i = 0; bus.dir_i = 2'd1; bus.dir_valid_i = 0;
    bus.target_x_i = 8'd10; bus.target_y_i = 7'd10;
    bus.addrh_i = '0; bus.addrv_i = '0;
    test_reset();
    test_move();
    test_reversal();
    test_wrap();
    test_target();
    test_self_hit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
